// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial two's-complement subtractor (a - b) with overflow/borrow flags
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             overflow,
  output logic             borrow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a_sh;
  logic [WIDTH-1:0]  r_b_sh;
  logic [CW-1:0]     r_cnt;
  logic              r_carry;
  logic              r_a_msb;
  logic              r_b_msb;
  logic              r_armed;

  logic [DIGIT:0]    w_sum;
  logic [WIDTH-1:0]  w_res_next;
  logic              w_last;

  // a + ~b + carry, one digit at a time; carry starts at 1 for the two's-complement +1
  assign w_sum  = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, ~r_b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  assign w_last = (r_cnt == CW'(N - 1));

  // The lowest digit of the result shift register is always shifted out before use,
  // so only the upper WIDTH-DIGIT bits are stored.
  generate
    if (N == 1) begin : g_single
      assign w_res_next = w_sum[DIGIT-1:0];
    end else begin : g_multi
      logic [WIDTH-DIGIT-1:0] r_res;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_res <= '0;
        end else if (r_state == S_RUN) begin
          r_res <= w_res_next[WIDTH-1:DIGIT];
        end
      end

      assign w_res_next = {w_sum[DIGIT-1:0], r_res};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_armed  <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      diff     <= '0;
      overflow <= 1'b0;
      borrow   <= 1'b0;
    end else begin
      // The edge on which rst_n rises only arms the block; it never accepts start.
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start && r_armed) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_cnt   <= '0;
            r_carry <= 1'b1;
            ready   <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sh  <= r_a_sh >> DIGIT;
          r_b_sh  <= r_b_sh >> DIGIT;
          r_carry <= w_sum[DIGIT];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            diff     <= w_res_next;
            borrow   <= ~w_sum[DIGIT];
            overflow <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
            done     <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at DIGIT=1 and DIGIT=4
module tb_serial_subtractor;

  typedef struct packed {
    logic [31:0] diff;
    logic        ovf;
    logic        brw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  logic        rdy1, dn1, ov1, br1;
  logic [31:0] diff1;
  logic        rdy4, dn4, ov4, br4;
  logic [31:0] diff4;

  int cur_sel = 0;
  int n_vec   = 0;
  int n_miss  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a_in), .b(b_in),
    .ready(rdy1), .done(dn1), .diff(diff1), .overflow(ov1), .borrow(br1)
  );

  serial_subtractor #(.WIDTH(32), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a_in), .b(b_in),
    .ready(rdy4), .done(dn4), .diff(diff4), .overflow(ov4), .borrow(br4)
  );

  wire        c_ready = (cur_sel == 0) ? rdy1  : rdy4;
  wire        c_done  = (cur_sel == 0) ? dn1   : dn4;
  wire [31:0] c_diff  = (cur_sel == 0) ? diff1 : diff4;
  wire        c_ovf   = (cur_sel == 0) ? ov1   : ov4;
  wire        c_brw   = (cur_sel == 0) ? br1   : br4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                    input int lat, input bit inject);
    exp_t e;
    int   k;
    bit   got;
    bit   seen_ready;
    cur_sel = sel;
    e.diff = av - bv;
    e.brw  = (av < bv);
    e.ovf  = (av[31] != bv[31]) && (e.diff[31] != av[31]);
    sb.push_back(e);
    @(negedge clk);
    a_in = av;
    b_in = bv;
    if (sel == 0) start1 = 1'b1; else start4 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    k = 0; got = 0; seen_ready = 0;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (inject && k == 5) begin start1 = 1'b1; a_in = 32'hFFFF_FFFF; b_in = 32'h0; end
      if (inject && k == 6) begin start1 = 1'b0; a_in = $urandom; b_in = $urandom; end
      if (c_done) got = 1;
      else if (c_ready) seen_ready = 1;
    end
    chk("latency", 32'(k - 1), 32'(lat));
    chk("ready_low_in_run", {31'b0, seen_ready}, 32'h0);
    if (sb.size() > 0) e = sb.pop_front();
    if (got) begin
      chk("diff", c_diff, e.diff);
      chk("overflow", {31'b0, c_ovf}, {31'b0, e.ovf});
      chk("borrow", {31'b0, c_brw}, {31'b0, e.brw});
      chk("ready_in_done", {31'b0, c_ready}, 32'h0);
      @(negedge clk);
      chk("ready_back", {31'b0, c_ready}, 32'h1);
      chk("done_one_cycle", {31'b0, c_done}, 32'h0);
    end
  endtask

  initial begin
    int dones;
    logic [31:0] r;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, rdy1}, 32'h1);
    chk("rst_done", {31'b0, dn1}, 32'h0);
    chk("rst_diff", diff1, 32'h0);
    chk("rst_ovf", {31'b0, ov1}, 32'h0);
    chk("rst_brw", {31'b0, br1}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    op(0, 32'h8000_0000, 32'h0000_0001, 32, 0);
    op(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32, 0);
    op(0, 32'h0000_0000, 32'h0000_0001, 32, 0);
    op(0, 32'h9999_9999, 32'h8765_4321, 32, 0);

    op(0, 32'h3333_3333, 32'h1111_1111, 32, 1);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (dn1) dones++;
    end
    chk("no_second_op", 32'(dones), 32'h0);
    chk("diff_holds", diff1, 32'h2222_2222);

    @(negedge clk);
    a_in = 32'h1234_5678;
    b_in = 32'h0000_0042;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'b0, rdy1}, 32'h1);
    chk("abort_done", {31'b0, dn1}, 32'h0);
    chk("abort_diff", diff1, 32'h0);
    chk("abort_brw", {31'b0, br1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (dn1) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'h0);
    op(0, 32'd5, 32'd7, 32, 0);

    op(1, 32'h7FFF_FFFF, 32'h8000_0000, 8, 0);
    op(1, 32'h0000_0000, 32'h0000_0000, 8, 0);
    op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8, 0);
    r = $urandom;
    op(1, r, r, 8, 0);
    for (int i = 0; i < 1000; i++) begin
      op(1, $urandom, $urandom, 8, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle, digit-serial two's-complement subtractor computing `a - b` with signed-overflow and unsigned-borrow flags. It is the inverse-direction companion of the ALU's parallel adders. It trades latency for area by processing `DIGIT` bits per clock, LSB-first, through a single narrow borrow chain. A start/ready/done handshake lets a sequential ALU controller issue one subtraction at a time.

## Interface
- `WIDTH`, default 32: operand and result width in bits. Must be ≥ 2.
- `DIGIT`, default 1: bits processed per clock. Must divide `WIDTH` exactly. N = `WIDTH`/`DIGIT` digit steps per operation.
- `clk`  input  1: single clock, rising-edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: request. Sampled only when `ready`=1.
- `a`  input  WIDTH: minuend. Captured on the accepting edge.
- `b`  input  WIDTH: subtrahend. Captured on the accepting edge.
- `ready`  output  1: block is idle and will accept `start`.
- `done`  output  1: one-cycle pulse; results valid and updated this cycle.
- `diff`  output  WIDTH: `a - b` mod 2^WIDTH.
- `overflow`  output  1: signed overflow, i.e. `a`[MSB] != `b`[MSB] and `diff`[MSB] != `a`[MSB].
- `borrow`  output  1: unsigned borrow, i.e. 1 iff `a` < `b` unsigned.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `ready`=1.
  - `start`=1 at an edge: latch `a`, `b` into internal shift registers, set digit counter to 0, set internal carry to 1 (two's-complement +1), go to RUN.
- **RUN**
  - `ready`=0.
  - Each edge: take the low `DIGIT` bits of the `a`-shift and the inverted low `DIGIT` bits of the `b`-shift, add them with the carry, shift the `DIGIT`-bit sum into the result register from the top, shift both operand registers right by `DIGIT`, update the carry, and increment the counter.
  - On the edge that processes digit N-1: write the full result to `diff`, set `borrow` = NOT final carry, compute `overflow` from the latched operand MSBs and the result MSB, go to DONE.
- **DONE**
  - `done`=1, `ready`=0, for exactly one cycle.
  - Next edge: go to IDLE.
- `start` outside IDLE is ignored and is not queued.
- Changes on `a`/`b` after the accepting edge have no effect.
- `diff`, `overflow`, and `borrow` are registered. They change only on the completing edge and hold until the next completion, including through subsequent IDLE/RUN periods.
- The internal result shift register is separate from `diff`, so `diff` never shows partial results.

## Timing
- Reset (async assert, `rst_n`=0):
  - State goes to IDLE; `ready`=1, `done`=0, `diff`=0, `overflow`=0, `borrow`=0.
  - Internal registers and the counter are cleared.
- Deassertion is taken synchronously at the next edge. No operation may be accepted on the edge where `rst_n` rises.
- With `start` accepted at edge t0:
  - RUN edges are t0+1 … t0+N.
  - Results and `done` appear after edge t0+N.
  - `ready` returns after edge t0+N+1.
  - Latency is N edges; issue interval is N+2 cycles minimum.
- `start` held high continuously is re-accepted at the first IDLE edge, one cycle after `done`.
- Reset mid-RUN or during DONE aborts the operation: no `done` pulse, and outputs return to reset values.
- Counter width is ceil(log2(N)), minimum 1. For N=1 (`DIGIT`=`WIDTH`), RUN lasts a single edge.
- All-ones/all-zeros boundaries:
  - 0 - 0 gives `diff`=0, `borrow`=0.
  - x - x gives 0 with `borrow`=0 for all x.

## Test plan
- `WIDTH`=32, `DIGIT`=1: `a`=0x80000000, `b`=0x00000001, `start` pulse → `done` exactly 32 edges after acceptance; `diff`=0x7FFFFFFF, `overflow`=1, `borrow`=0. `ready` low throughout; back high one cycle after `done`.
- `a`=0x7FFFFFFF, `b`=0xFFFFFFFF → `diff`=0x80000000, `overflow`=1, `borrow`=1.
- `a`=0x00000000, `b`=0x00000001 → `diff`=0xFFFFFFFF, `overflow`=0, `borrow`=1. Then `a`=0x99999999, `b`=0x87654321 → `diff`=0x12345678, `overflow`=0, `borrow`=0.
- Accept `a`=0x33333333, `b`=0x11111111. During RUN, pulse `start` with `a`=0xFFFFFFFF, `b`=0 and change the inputs → single `done`, `diff`=0x22222222. No second operation starts, and `diff` holds 0x22222222 through the following idle cycles.
- Deassert `rst_n` at RUN step 10 → immediate `ready`=1, `done`=0, `diff`=0. No `done` pulse for the aborted operation. A fresh 5 - 7 afterwards gives `diff`=0xFFFFFFFE, `borrow`=1.
- `DIGIT`=4: `a`=0x7FFFFFFF, `b`=0x80000000 → `done` 8 edges after acceptance; `diff`=0xFFFFFFFF, `overflow`=1, `borrow`=1. Also sweep 1000 random pairs against a reference `a - b` model.
